// File: rtl/bcd_autoscale_converter.sv
`timescale 1ns/1ps
// Sequential binary-to-BCD converter (double dabble, one bit per clock) that
// autoscales the result down to four displayed digits plus a decimal-shift count.
module bcd_autoscale_converter #(
    parameter int BINARY_WIDTH = 24,
    parameter int BCD_DIGITS   = 8,
    parameter int SHIFT_WIDTH  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BINARY_WIDTH-1:0] binary_in,
    output logic                    ready,
    output logic                    done_tick,
    output logic [3:0]              bcd3,
    output logic [3:0]              bcd2,
    output logic [3:0]              bcd1,
    output logic [3:0]              bcd0,
    output logic [SHIFT_WIDTH-1:0]  autoscale_shifts
);

    localparam int BCD_W = BCD_DIGITS * 4;
    localparam int N_W   = $clog2(BINARY_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CONVERT, SCALE, DONE} state_t;

    state_t                  state_q;
    logic [BINARY_WIDTH-1:0] shift_reg_q;
    logic [BCD_W-1:0]        bcd_work_q;
    logic [N_W-1:0]          n_q;
    logic [SHIFT_WIDTH-1:0]  s_q;
    logic                    ready_q;
    logic                    done_q;
    logic [15:0]             digits_q;
    logic [SHIFT_WIDTH-1:0]  shifts_q;

    logic [BCD_W-1:0]              bcd_adj;
    logic [BCD_W+BINARY_WIDTH-1:0] dabble_d;
    logic [BCD_W-1:0]              bcd_scaled_d;
    logic                          upper_nonzero;
    logic [3:0]                    digit;

    // Add-3 correction on every digit, then shift the joint {bcd, binary} register.
    always_comb begin
        bcd_adj = '0;
        digit   = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            digit = bcd_work_q[4*i +: 4];
            bcd_adj[4*i +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
        end
        dabble_d      = {bcd_adj, shift_reg_q} << 1;
        bcd_scaled_d  = {4'd0, bcd_work_q[BCD_W-1:4]};
        upper_nonzero = |bcd_work_q[BCD_W-1:16];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_reg_q <= '0;
            bcd_work_q  <= '0;
            n_q         <= '0;
            s_q         <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            digits_q    <= '0;
            shifts_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_reg_q <= binary_in;
                        bcd_work_q  <= '0;
                        n_q         <= N_W'(BINARY_WIDTH);
                        s_q         <= '0;
                        ready_q     <= 1'b0;
                        state_q     <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd_work_q  <= dabble_d[BCD_W+BINARY_WIDTH-1:BINARY_WIDTH];
                    shift_reg_q <= dabble_d[BINARY_WIDTH-1:0];
                    n_q         <= n_q - N_W'(1);
                    if (n_q == N_W'(1)) begin
                        state_q <= SCALE;
                    end
                end
                SCALE: begin
                    // Truncating scale: drop the lowest digit until only four remain.
                    if (upper_nonzero) begin
                        bcd_work_q <= bcd_scaled_d;
                        s_q        <= s_q + SHIFT_WIDTH'(1);
                    end else begin
                        digits_q <= bcd_work_q[15:0];
                        shifts_q <= s_q;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready            = ready_q;
    assign done_tick        = done_q;
    assign bcd3             = digits_q[15:12];
    assign bcd2             = digits_q[11:8];
    assign bcd1             = digits_q[7:4];
    assign bcd0             = digits_q[3:0];
    assign autoscale_shifts = shifts_q;

endmodule

// File: tb/tb_bcd_autoscale_converter.sv
`timescale 1ns/1ps
// Directed bench for bcd_autoscale_converter: digits, shift count, latency,
// start filtering, mid-conversion reset and back-to-back operation.
module tb_bcd_autoscale_converter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [23:0] binary_in;
    logic        ready;
    logic        done_tick;
    logic [3:0]  bcd3, bcd2, bcd1, bcd0;
    logic [2:0]  autoscale_shifts;

    int checks   = 0;
    int failures = 0;

    bcd_autoscale_converter #(
        .BINARY_WIDTH(24),
        .BCD_DIGITS  (8),
        .SHIFT_WIDTH (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .binary_in       (binary_in),
        .ready           (ready),
        .done_tick       (done_tick),
        .bcd3            (bcd3),
        .bcd2            (bcd2),
        .bcd1            (bcd1),
        .bcd0            (bcd0),
        .autoscale_shifts(autoscale_shifts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] digits();
        return {bcd3, bcd2, bcd1, bcd0};
    endfunction

    // One conversion; exp_edges counts clock edges after the accepting edge.
    task automatic convert(input string tag, input logic [23:0] val, input logic [15:0] exp_dig,
                           input int exp_sh, input int exp_edges);
        int edges;
        edges = -1;
        @(negedge clk);
        start     = 1'b1;
        binary_in = val;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        binary_in = 24'($urandom);
        check_val({tag, "_busy"}, 32'(ready), 32'd0);
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1;
            if (done_tick) begin
                edges = e;
                break;
            end
        end
        check_val({tag, "_latency"}, 32'(edges), 32'(exp_edges));
        check_val({tag, "_digits"}, 32'(digits()), 32'(exp_dig));
        check_val({tag, "_shifts"}, 32'(autoscale_shifts), 32'(exp_sh));
        check_val({tag, "_ready_in_done"}, 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        check_val({tag, "_done_one_cycle"}, 32'(done_tick), 32'd0);
        check_val({tag, "_ready_after"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int done_cnt;
        int done_edge;
        int second_edge;

        reset     = 1'b1;
        start     = 1'b0;
        binary_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready", 32'(ready), 32'd1);
        check_val("rst_done", 32'(done_tick), 32'd0);
        check_val("rst_digits", 32'(digits()), 32'd0);
        check_val("rst_shifts", 32'(autoscale_shifts), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        convert("zero",  24'd0,        16'h0000, 0, 25);
        convert("v1234", 24'd1234,     16'h1234, 0, 25);
        convert("v9999", 24'd9999,     16'h9999, 0, 25);
        convert("v10000", 24'd10000,   16'h1000, 1, 26);
        convert("v99999", 24'd99999,   16'h9999, 1, 26);
        convert("vmax",  24'd16777215, 16'h1677, 4, 29);
        convert("v12345678", 24'd12345678, 16'h1234, 4, 29);

        // start pulses during an active conversion must be ignored
        done_cnt  = 0;
        done_edge = -1;
        @(negedge clk);
        start     = 1'b1;
        binary_in = 24'd4321;
        @(posedge clk);
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            start     = (e == 5 || e == 20);
            binary_in = 24'd8765;
            if (e == 10) begin
                check_val("ign_hold_digits", 32'(digits()), 32'h1234);
                check_val("ign_hold_shifts", 32'(autoscale_shifts), 32'd4);
            end
            @(posedge clk);
            #1;
            if (done_tick) begin
                done_cnt++;
                if (done_edge < 0) done_edge = e;
            end
        end
        check_val("ign_done_count", 32'(done_cnt), 32'd1);
        check_val("ign_done_edge", 32'(done_edge), 32'd25);
        check_val("ign_digits", 32'(digits()), 32'h4321);
        check_val("ign_shifts", 32'(autoscale_shifts), 32'd0);

        // reset in the middle of a conversion
        done_cnt = 0;
        @(negedge clk);
        start     = 1'b1;
        binary_in = 24'd99999;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (done_tick) done_cnt++;
        end
        #1;
        reset = 1'b1;
        #1;
        check_val("abort_ready", 32'(ready), 32'd1);
        check_val("abort_done", 32'(done_tick), 32'd0);
        check_val("abort_digits", 32'(digits()), 32'd0);
        check_val("abort_shifts", 32'(autoscale_shifts), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (done_tick) done_cnt++;
        end
        check_val("abort_no_done", 32'(done_cnt), 32'd0);
        convert("after_abort", 24'd42, 16'h0042, 0, 25);

        // start held high: second conversion begins right after DONE->IDLE
        done_edge   = -1;
        second_edge = -1;
        @(negedge clk);
        start     = 1'b1;
        binary_in = 24'd1234;
        @(posedge clk);
        for (int e = 1; e <= 70; e++) begin
            @(posedge clk);
            #1;
            if (done_tick) begin
                if (done_edge < 0) begin
                    done_edge = e;
                end else begin
                    second_edge = e;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check_val("b2b_first", 32'(done_edge), 32'd25);
        check_val("b2b_second", 32'(second_edge), 32'd52);
        check_val("b2b_digits", 32'(digits()), 32'h1234);
        repeat (3) @(posedge clk);
        #1;
        check_val("b2b_idle_ready", 32'(ready), 32'd1);
        check_val("b2b_idle_done", 32'(done_tick), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
